// File: rtl/cmd_pkg.sv
// Shared types for the real-time command write path: packed command layout,
// field widths and the arbiter FSM state encoding.
package cmd_pkg;

    localparam int FREQ_W = 48;
    localparam int RATE_W = 32;
    localparam int TIME_W = 64;
    localparam int NIMP_W = 16;
    localparam int TYPE_W = 2;
    localparam int INT_W  = 32;

    // MSB first: FREQ occupies [337:290], Tblank2 occupies [31:0].
    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [FREQ_W-1:0] freq_step;
        logic [RATE_W-1:0] freq_rate;
        logic [TIME_W-1:0] time_start;
        logic [NIMP_W-1:0] n_impulse;
        logic [TYPE_W-1:0] type_impulse;
        logic [INT_W-1:0]  interval_ti;
        logic [INT_W-1:0]  interval_tp;
        logic [INT_W-1:0]  tblank1;
        logic [INT_W-1:0]  tblank2;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/cmd_write_arbiter_rr_arb2.sv
// Two-way round-robin grant. On a tie the source that did not win last time
// is chosen; the history only advances when the caller reports a taken grant.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    logic rr_last_q;

    always_comb begin
        gnt_vld_o = |req_i;
        gnt_idx_o = 1'b0;
        if (req_i == 2'b10) begin
            gnt_idx_o = 1'b1;
        end else if (req_i == 2'b11) begin
            gnt_idx_o = ~rr_last_q;
        end
    end

    // Reset to 1 so source 0 wins the first tie after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last_q <= 1'b1;
        end else if (take_i) begin
            rr_last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/cmd_write_arbiter.sv
// Merges two command sources into the single wcm write port: round-robin grant,
// late-command rejection against live TIME, SPI_WR strobe and inter-write gap.
module cmd_write_arbiter
    import cmd_pkg::*;
#(
    parameter int INIT_CYC = 300,
    parameter int WR_LEN   = 5,
    parameter int GAP_LEN  = 4,
    parameter int LEAD_CYC = 48
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [CMD_W-1:0]  s0_cmd,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [CMD_W-1:0]  s1_cmd,
    input  logic [TIME_W-1:0] TIME,
    input  logic              late_chk_en,
    output logic [CMD_W-1:0]  wr_cmd,
    output logic              SPI_WR,
    output logic              busy,
    output logic              init_done,
    output logic              rej_pulse,
    output logic [7:0]        rej_cnt0,
    output logic [7:0]        rej_cnt1
);

    localparam int CNT_W = $clog2(INIT_CYC + WR_LEN + GAP_LEN + 1);
    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(WR_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_LEN - 1);
    localparam logic [TIME_W:0]   LEAD_EXT  = (TIME_W+1)'(LEAD_CYC);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    cmd_t             wr_cmd_q;
    logic             gnt_q;
    logic             spi_wr_q;
    logic             busy_q;
    logic             init_done_q;
    logic             rej_pulse_q;
    logic [7:0]       rej_cnt0_q;
    logic [7:0]       rej_cnt1_q;

    logic             gnt_vld;
    logic             gnt_idx;
    logic             take;
    logic             late;

    // Handshake: a source holds valid and its command stable until it sees
    // ready high; ready is high for exactly the IDLE cycle in which that
    // source is granted, and the transfer completes at the end of that cycle.
    assign take     = (state_q == ST_IDLE) && gnt_vld;
    assign s0_ready = take && !gnt_idx;
    assign s1_ready = take && gnt_idx;

    rr_arb2 u_rr_arb2 (
        .clk_i     (CLK),
        .rst_ni    (rst_n),
        .req_i     ({s1_valid, s0_valid}),
        .take_i    (take),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // One extra bit so TIME near the top of its range cannot wrap into an accept.
    assign late = late_chk_en &&
                  ({1'b0, wr_cmd_q.time_start} < ({1'b0, TIME} + LEAD_EXT));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            wr_cmd_q    <= '0;
            gnt_q       <= 1'b0;
            spi_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            rej_pulse_q <= 1'b0;
            rej_cnt0_q  <= '0;
            rej_cnt1_q  <= '0;
        end else begin
            rej_pulse_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    busy_q <= 1'b1;
                    if (cnt_q == INIT_LAST) begin
                        cnt_q       <= '0;
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (take) begin
                        wr_cmd_q <= gnt_idx ? cmd_t'(s1_cmd) : cmd_t'(s0_cmd);
                        gnt_q    <= gnt_idx;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    cnt_q <= '0;
                    if (late) begin
                        rej_pulse_q <= 1'b1;
                        if (!gnt_q && rej_cnt0_q != 8'hFF) begin
                            rej_cnt0_q <= rej_cnt0_q + 8'd1;
                        end
                        if (gnt_q && rej_cnt1_q != 8'hFF) begin
                            rej_cnt1_q <= rej_cnt1_q + 8'd1;
                        end
                        state_q <= ST_GAP;
                    end else begin
                        spi_wr_q <= 1'b1;
                        state_q  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == WR_LAST) begin
                        cnt_q    <= '0;
                        spi_wr_q <= 1'b0;
                        state_q  <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign wr_cmd    = wr_cmd_q;
    assign SPI_WR    = spi_wr_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign rej_pulse = rej_pulse_q;
    assign rej_cnt0  = rej_cnt0_q;
    assign rej_cnt1  = rej_cnt1_q;

endmodule

// File: tb/tb_cmd_write_arbiter.sv
// Directed bench for cmd_write_arbiter: expected writes go into a queue when
// issued, a negedge monitor pops and checks them at each SPI_WR rise.
module tb_cmd_write_arbiter;
    import cmd_pkg::*;

    logic              CLK;
    logic              rst_n;
    logic              s0_valid;
    logic              s0_ready;
    cmd_t              s0_cmd;
    logic              s1_valid;
    logic              s1_ready;
    cmd_t              s1_cmd;
    logic [63:0]       tb_time;
    logic              late_chk_en;
    logic [CMD_W-1:0]  wr_cmd;
    logic              SPI_WR;
    logic              busy;
    logic              init_done;
    logic              rej_pulse;
    logic [7:0]        rej_cnt0;
    logic [7:0]        rej_cnt1;

    cmd_write_arbiter dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .s0_valid    (s0_valid),
        .s0_ready    (s0_ready),
        .s0_cmd      (s0_cmd),
        .s1_valid    (s1_valid),
        .s1_ready    (s1_ready),
        .s1_cmd      (s1_cmd),
        .TIME        (tb_time),
        .late_chk_en (late_chk_en),
        .wr_cmd      (wr_cmd),
        .SPI_WR      (SPI_WR),
        .busy        (busy),
        .init_done   (init_done),
        .rej_pulse   (rej_pulse),
        .rej_cnt0    (rej_cnt0),
        .rej_cnt1    (rej_cnt1)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc;
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [CMD_W-1:0] exp_q[$];
    logic [CMD_W-1:0] cur_exp;
    int n_pulse   = 0;
    int n_rej     = 0;
    int last_rise = -1;
    int last_fall = -1;
    int gnt_cyc   = 0;
    int hi_len    = 0;
    logic prev_wr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act !== req) begin
            bad_cnt++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic [31:0] tag, input logic [63:0] ts);
        cmd_t c;
        c              = '0;
        c.freq         = {16'hF00D, tag};
        c.freq_step    = {16'hBEEF, ~tag};
        c.freq_rate    = tag ^ 32'h5A5A_5A5A;
        c.time_start   = ts;
        c.n_impulse    = tag[15:0] + 16'd3;
        c.type_impulse = tag[1:0];
        c.interval_ti  = tag + 32'd100;
        c.interval_tp  = tag + 32'd200;
        c.tblank1      = {tag[15:0], 16'h1111};
        c.tblank2      = {16'h2222, tag[15:0]};
        return c;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (!rst_n) begin
            prev_wr = 1'b0;
            hi_len  = 0;
        end else begin
            if (s0_ready || s1_ready) gnt_cyc = cyc;
            if (rej_pulse) n_rej++;
            if (SPI_WR && !prev_wr) begin
                last_rise = cyc;
                n_pulse++;
                hi_len = 1;
                chk("grant_to_wr_latency", 64'(cyc - gnt_cyc), 64'd2);
                total_cnt++;
                if (exp_q.size() == 0) begin
                    bad_cnt++;
                    $display("FAIL unexpected_write: wr_cmd=%h, required no write", wr_cmd);
                end else begin
                    cur_exp = exp_q.pop_front();
                    if (wr_cmd !== cur_exp) begin
                        bad_cnt++;
                        $display("FAIL wr_cmd: got %h, required %h", wr_cmd, cur_exp);
                    end
                end
            end else if (SPI_WR) begin
                hi_len++;
            end else if (prev_wr) begin
                last_fall = cyc;
                chk("spi_wr_width", 64'(hi_len), 64'd5);
                total_cnt++;
                if (wr_cmd !== cur_exp) begin
                    bad_cnt++;
                    $display("FAIL wr_cmd_hold: got %h, required %h", wr_cmd, cur_exp);
                end
            end
            prev_wr = SPI_WR;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int src, input cmd_t c, output int rc);
        rc = -1;
        @(posedge CLK);
        #1;
        if (src == 0) begin s0_cmd = c; s0_valid = 1'b1; end
        else          begin s1_cmd = c; s1_valid = 1'b1; end
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if ((src == 0 && s0_ready) || (src == 1 && s1_ready)) begin
                rc = cyc;
                break;
            end
        end
        @(posedge CLK);
        #1;
        if (src == 0) s0_valid = 1'b0;
        else          s1_valid = 1'b0;
        if (rc < 0) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL send_timeout: src %0d saw no ready, required ready within 1000 cycles", src);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL idle_timeout: busy still 1, required 0 within 100 cycles");
        end
    endtask

    // ---------------- stimulus ----------------
    int   r0, r1, p0, j0;
    cmd_t c0, c1;
    bit   seen;

    initial begin
        rst_n       = 1'b0;
        s0_valid    = 1'b0;
        s1_valid    = 1'b0;
        s0_cmd      = '0;
        s1_cmd      = '0;
        tb_time     = 64'd0;
        late_chk_en = 1'b1;
        #1;
        chk("rst_spi_wr",    64'(SPI_WR),    64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_ready",     64'(s0_ready | s1_ready), 64'd0);
        chk("rst_rej_pulse", 64'(rej_pulse), 64'd0);
        chk("rst_rej_cnt",   64'({rej_cnt1, rej_cnt0}), 64'd0);
        chk("rst_wr_cmd",    64'(|wr_cmd),   64'd0);
        repeat (3) @(posedge CLK);
        #1 rst_n = 1'b1;

        // first command waits out the post-reset clear
        while (cyc < 9) begin @(posedge CLK); #1; end
        c0 = mk_cmd(32'h0000_0001, 64'h12C0);
        exp_q.push_back(c0);
        send(0, c0, r0);
        chk("init_ready_cycle", 64'(r0), 64'd300);
        chk("init_done_high", 64'(init_done), 64'd1);
        wait_idle();
        chk("first_rise_cycle", 64'(last_rise), 64'd302);
        chk("first_fall_cycle", 64'(last_fall), 64'd307);

        // late s1 command rejected, then accepted with checking disabled
        tb_time = 64'h0FE0;
        p0 = n_pulse; j0 = n_rej;
        c1 = mk_cmd(32'h0000_0010, 64'h1000);
        send(1, c1, r1);
        wait_idle();
        chk("late_no_write", 64'(n_pulse - p0), 64'd0);
        chk("late_rej_pulses", 64'(n_rej - j0), 64'd1);
        chk("late_rej_cnt1", 64'(rej_cnt1), 64'd1);
        late_chk_en = 1'b0;
        exp_q.push_back(c1);
        send(1, c1, r1);
        wait_idle();
        chk("nochk_written", 64'(n_pulse - p0), 64'd1);
        chk("nochk_rej_cnt1", 64'(rej_cnt1), 64'd1);
        late_chk_en = 1'b1;

        // simultaneous requests twice: s0 first each time, 11 cycles apart
        tb_time = 64'd0;
        for (int k = 0; k < 2; k++) begin
            c0 = mk_cmd(32'h0000_0100 + 32'(k), 64'h12C0);
            c1 = mk_cmd(32'h0000_0200 + 32'(k), 64'h12C0);
            exp_q.push_back(c0);
            exp_q.push_back(c1);
            p0 = n_pulse;
            fork
                send(0, c0, r0);
                send(1, c1, r1);
            join
            wait_idle();
            chk("pair_spacing", 64'(r1 - r0), 64'd11);
            chk("pair_pulses", 64'(n_pulse - p0), 64'd2);
        end

        // lead boundary cases
        tb_time = 64'h2000;
        p0 = n_pulse; j0 = n_rej;
        c0 = mk_cmd(32'h0000_0300, 64'h2030);
        exp_q.push_back(c0);
        send(0, c0, r0);
        wait_idle();
        chk("lead48_written", 64'(n_pulse - p0), 64'd1);
        chk("lead48_no_rej", 64'(n_rej - j0), 64'd0);
        c0 = mk_cmd(32'h0000_0301, 64'h202F);
        send(0, c0, r0);
        wait_idle();
        chk("lead47_rej_cnt0", 64'(rej_cnt0), 64'd1);
        chk("lead47_no_write", 64'(n_pulse - p0), 64'd1);
        tb_time = 64'hFFFF_FFFF_FFFF_FFF0;
        c0 = mk_cmd(32'h0000_0302, 64'hFFFF_FFFF_FFFF_FFFF);
        send(0, c0, r0);
        wait_idle();
        chk("wrap_rej_cnt0", 64'(rej_cnt0), 64'd2);
        chk("wrap_no_write", 64'(n_pulse - p0), 64'd1);

        // saturation of the s0 reject counter
        tb_time = 64'h1_0000;
        j0 = n_rej;
        for (int k = 0; k < 300; k++) begin
            c0 = mk_cmd(32'h0001_0000 + 32'(k), 64'd0);
            send(0, c0, r0);
            wait_idle();
        end
        chk("sat_rej_pulses", 64'(n_rej - j0), 64'd300);
        chk("sat_rej_cnt0", 64'(rej_cnt0), 64'd255);

        // reset in the third WRITE cycle
        tb_time = 64'd0;
        c0 = mk_cmd(32'h0000_0400, 64'h12C0);
        exp_q.push_back(c0);
        send(0, c0, r0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (SPI_WR) begin seen = 1'b1; break; end
        end
        chk("pre_reset_write_seen", 64'(seen), 64'd1);
        repeat (2) @(negedge CLK);
        chk("third_write_cycle_high", 64'(SPI_WR), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_spi_wr_drop", 64'(SPI_WR), 64'd0);
        chk("async_init_done", 64'(init_done), 64'd0);
        chk("async_rej_cnt", 64'({rej_cnt1, rej_cnt0}), 64'd0);
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        c0 = mk_cmd(32'h0000_0500, 64'h12C0);
        exp_q.push_back(c0);
        send(0, c0, r0);
        chk("post_reset_ready_cycle", 64'(r0), 64'd300);
        wait_idle();
        chk("post_reset_rise_cycle", 64'(last_rise), 64'd302);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/cmd_write_arbiter.md
Name: cmd_write_arbiter

Overview:
- Merges real-time command writes from two requesters (MCU SPI decoder = source 0, host link decoder = source 1) into the single write port of the real-time command register (wcm).
- Round-robin arbitration; holds the command stable and generates the SPI_WR strobe and inter-write gap.
- Rejects commands whose TIME_START is already too close to the current system TIME.
- Suppresses all writes until the register's post-reset buffer clear has finished.

Parameters:
- INIT_CYC, 300, CLK cycles after reset before the first write is allowed (covers the 6 us buffer clear at 48 MHz).
- WR_LEN, 5, SPI_WR high time in cycles.
- GAP_LEN, 4, minimum SPI_WR low time between writes, in cycles.
- LEAD_CYC, 48, minimum lead of TIME_START over TIME for acceptance (1 us).

Ports:
- CLK  in  1  system clock, 48 MHz
- rst_n  in  1  reset; asynchronous assert, active-low
- s0_valid  in  1  source 0 command valid
- s0_ready  out  1  source 0 accept strobe
- s0_cmd  in  338  source 0 packed command (cmd_t)
- s1_valid  in  1  source 1 command valid
- s1_ready  out  1  source 1 accept strobe
- s1_cmd  in  338  source 1 packed command (cmd_t)
- TIME  in  64  current system time from the synchronizer
- late_chk_en  in  1  1 = enable late-command rejection
- wr_cmd  out  338  command presented to the wcm data inputs
- SPI_WR  out  1  write strobe to wcm
- busy  out  1  high in every state except IDLE
- init_done  out  1  high once the INIT wait has elapsed
- rej_pulse  out  1  one-cycle pulse per rejected command
- rej_cnt0  out  8  saturating reject count, source 0
- rej_cnt1  out  8  saturating reject count, source 1

Behaviour:
- cmd_t packing, MSB first:
  - FREQ[337:290], FREQ_STEP[289:242], FREQ_RATE[241:210]
  - TIME_START[209:146], N_impulse[145:130], TYPE_impulse[129:128]
  - Interval_Ti[127:96], Interval_Tp[95:64], Tblank1[63:32], Tblank2[31:0]
- Reset values: all outputs 0, state INIT, wait counter 0, rr_last=1 so source 0 wins the first tie.
- FSM states: INIT, IDLE, CHECK, WRITE, GAP.
- INIT:
  - Counter runs 0..INIT_CYC-1; then init_done=1 (stays 1 until next reset) and go to IDLE.
  - Requests are ignored; readies stay 0.
- IDLE:
  - If any valid: grant one source. Single request wins. Both valid: the source != rr_last wins.
  - In the grant cycle: sK_ready=1 for exactly that cycle (combinational on state and valid); wr_cmd<=sK_cmd; gnt<=K; rr_last<=K; next state CHECK.
  - The loser's valid stays pending and must be held by its source.
- CHECK (1 cycle), using TIME sampled in this cycle:
  - late = late_chk_en && ({1'b0,TIME_START} < {1'b0,TIME}+LEAD_CYC), computed 65-bit so there is no wrap.
  - late: rej_pulse=1 for one cycle; rej_cnt[gnt] increments, saturating at 255; next state GAP.
  - Not late: next state WRITE.
- WRITE: SPI_WR=1 for exactly WR_LEN cycles, then GAP.
- GAP: SPI_WR=0 for GAP_LEN cycles, then IDLE.
- wr_cmd is stable from CHECK to the end of GAP.
- Grant-to-SPI_WR-rise latency: 2 cycles.
- Minimum accept-to-accept spacing: 2+WR_LEN+GAP_LEN = 11 cycles (accepted); 1+1+GAP_LEN = 6 cycles (rejected).
- TIME jumps (SYS_TIME_UPDATE) need no special handling: the check uses the live TIME value in CHECK.
- rst_n low at any point: async return to INIT, SPI_WR drops immediately, counters clear, an in-flight command is lost. Sources re-present after ready.
- valid deasserted in IDLE: no transfer, no state change.

Decomposition:
- Package cmd_pkg:
  - cmd_t packed struct and CMD_W=338.
  - Field-width constants (FREQ_W=48, RATE_W=32, TIME_W=64, NIMP_W=16, TYPE_W=2, INT_W=32).
  - State enum state_t.
- Sub-module rr_arb2: 2-way round-robin grant with rr_last register, update-on-grant input.
- Counters and FSM live in the top module.

Test Plan:
- Reset release, s0_valid=1 from cycle 10 with TIME_START=0x12C0, TIME=0, late_chk_en=1 -> s0_ready only at cycle 300; SPI_WR high cycles 302..306; wr_cmd equals s0_cmd.
- After init, s0 and s1 valid in the same cycle, both on time -> s0 granted first, s1 granted 11 cycles later; 2 SPI_WR pulses, each 5 cycles; next simultaneous pair -> s0 then s1 again (rr_last=1 after s1).
- s1 command TIME_START=0x1000, TIME=0x0FE0 (lead 32<48), late_chk_en=1 -> no SPI_WR, rej_pulse once, rej_cnt1=1; same with late_chk_en=0 -> written normally.
- Boundary: TIME_START=TIME+48 -> accepted; TIME_START=TIME+47 -> rejected; TIME=0xFFFF_FFFF_FFFF_FFF0, TIME_START=0xFFFF_FFFF_FFFF_FFFF -> rejected, with no wrap-induced accept.
- 300 late s0 commands -> rej_cnt0 saturates at 255 and does not wrap.
- rst_n pulsed low at the third cycle of WRITE -> SPI_WR=0 asynchronously; init_done=0; rej counters 0; next accept no earlier than INIT_CYC cycles after release.
